// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - passive observer classifying 4-bit counter changes as step/wrap/hold/jump
// Optional jump classification is compiled in with COUNT_MONITOR_JUMP_EN.
module count_monitor #(
    parameter int STALL_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       cnt_in,
    input  logic             cnt_vld,
    input  logic             clr_stats,
    input  logic [3:0]       match_val,
    input  logic             match_en,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             jump_pulse,
    output logic             match_pulse,
    output logic             stall_flag,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [3:0]       last_val
);

    localparam int RUN_W = $clog2(STALL_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LEN);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_TRACK,
        S_STALL
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             match_q, match_d;
    logic             stall_q, stall_d;
    logic             jump_d;
    logic             jump_cnt_inc;

    logic [3:0] next_exp;
    logic       is_step;
    logic       is_hold;

    assign next_exp = last_q + 4'd1;
    assign is_step  = (cnt_in == next_exp);
    assign is_hold  = (cnt_in == last_q);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        last_d       = last_q;
        wrap_cnt_d   = wrap_cnt_q;
        step_d       = 1'b0;
        wrap_d       = 1'b0;
        match_d      = 1'b0;
        jump_d       = 1'b0;
        jump_cnt_inc = 1'b0;

        if (clr_stats) begin
            // Statistics and tracking restart; last_val intentionally survives.
            state_d    = S_EMPTY;
            run_d      = '0;
            wrap_cnt_d = '0;
        end else if (cnt_vld) begin
            match_d = match_en && (cnt_in == match_val);
            last_d  = cnt_in;
            if (state_q == S_EMPTY) begin
                state_d = S_TRACK;
                run_d   = '0;
            end else if (is_hold) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + 1'b1;
                end
                if (run_d == RUN_MAX) begin
                    state_d = S_STALL;
                end
            end else begin
                run_d   = '0;
                state_d = S_TRACK;
                if (is_step) begin
                    step_d = 1'b1;
                    if (last_q == 4'd15) begin
                        wrap_d = 1'b1;
                        if (wrap_cnt_q != {CNT_W{1'b1}}) begin
                            wrap_cnt_d = wrap_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    jump_d       = 1'b1;
                    jump_cnt_inc = 1'b1;
                end
            end
        end
        stall_d = (state_d == S_STALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            run_q      <= '0;
            last_q     <= '0;
            wrap_cnt_q <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            match_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            last_q     <= last_d;
            wrap_cnt_q <= wrap_cnt_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            match_q    <= match_d;
            stall_q    <= stall_d;
        end
    end

`ifdef COUNT_MONITOR_JUMP_EN
    logic             jump_q;
    logic [CNT_W-1:0] jump_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_q     <= 1'b0;
            jump_cnt_q <= '0;
        end else begin
            jump_q <= jump_d;
            if (clr_stats) begin
                jump_cnt_q <= '0;
            end else if (jump_cnt_inc && (jump_cnt_q != {CNT_W{1'b1}})) begin
                jump_cnt_q <= jump_cnt_q + 1'b1;
            end
        end
    end

    assign jump_pulse = jump_q;
    assign jump_cnt   = jump_cnt_q;
`else
    // Jump detection still drives the hold-run/stall exit above; only its outputs vanish.
    logic unused_jump;
    assign unused_jump = jump_d | jump_cnt_inc;
    assign jump_pulse  = 1'b0;
    assign jump_cnt    = '0;
`endif

    assign step_pulse  = step_q;
    assign wrap_pulse  = wrap_q;
    assign match_pulse = match_q;
    assign stall_flag  = stall_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign last_val    = last_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - directed and randomized self-checking bench for count_monitor
module tb_count_monitor;

    localparam int STALL_LEN = 8;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       cnt_in = 4'd0;
    logic             cnt_vld = 1'b0;
    logic             clr_stats = 1'b0;
    logic [3:0]       match_val = 4'd0;
    logic             match_en = 1'b0;
    logic             step_pulse, wrap_pulse, jump_pulse, match_pulse, stall_flag;
    logic [CNT_W-1:0] wrap_cnt, jump_cnt;
    logic [3:0]       last_val;

    count_monitor #(.STALL_LEN(STALL_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .clr_stats(clr_stats), .match_val(match_val), .match_en(match_en),
        .step_pulse(step_pulse), .wrap_pulse(wrap_pulse), .jump_pulse(jump_pulse),
        .match_pulse(match_pulse), .stall_flag(stall_flag), .wrap_cnt(wrap_cnt),
        .jump_cnt(jump_cnt), .last_val(last_val)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit m_have, m_stall, m_step, m_wrap, m_jump, m_match;
    int m_last, m_run, m_wcnt, m_jcnt;
    int step_seen;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_stall = 0; m_step = 0; m_wrap = 0; m_jump = 0; m_match = 0;
        m_last = 0; m_run = 0; m_wcnt = 0; m_jcnt = 0;
    endtask

    task automatic model_edge(bit vld, int val, bit clr);
        m_step = 0; m_wrap = 0; m_jump = 0; m_match = 0;
        if (clr) begin
            m_have = 0; m_run = 0; m_stall = 0; m_wcnt = 0; m_jcnt = 0;
        end else if (vld) begin
            m_match = match_en && (val == int'(match_val));
            if (!m_have) begin
                m_have = 1;
                m_run  = 0;
            end else if (val == m_last) begin
                m_run   = (m_run + 1 > STALL_LEN) ? STALL_LEN : m_run + 1;
                m_stall = (m_run >= STALL_LEN);
            end else begin
                m_run   = 0;
                m_stall = 0;
                if (val == (m_last + 1) % 16) begin
                    m_step = 1;
                    if (m_last == 15) begin
                        m_wrap = 1;
                        m_wcnt = (m_wcnt < CNT_MAX) ? m_wcnt + 1 : CNT_MAX;
                    end
                end else begin
`ifdef COUNT_MONITOR_JUMP_EN
                    m_jump = 1;
                    m_jcnt = (m_jcnt < CNT_MAX) ? m_jcnt + 1 : CNT_MAX;
`endif
                end
            end
            m_last = val;
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".step"},  32'(step_pulse),  32'(m_step));
        chk({tag, ".wrap"},  32'(wrap_pulse),  32'(m_wrap));
        chk({tag, ".jump"},  32'(jump_pulse),  32'(m_jump));
        chk({tag, ".match"}, 32'(match_pulse), 32'(m_match));
        chk({tag, ".stall"}, 32'(stall_flag),  32'(m_stall));
        chk({tag, ".wcnt"},  32'(wrap_cnt),    32'(m_wcnt));
        chk({tag, ".jcnt"},  32'(jump_cnt),    32'(m_jcnt));
        chk({tag, ".last"},  32'(last_val),    32'(m_last));
    endtask

    task automatic cyc(string tag, bit vld, int val, bit clr = 0);
        @(negedge clk);
        cnt_vld   = vld;
        cnt_in    = val[3:0];
        clr_stats = clr;
        @(posedge clk);
        model_edge(vld, val, clr);
        #1;
        check_all(tag);
        if (step_pulse === 1'b1) step_seen++;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // full count sequence 0..15 then wrap to 0
        step_seen = 0;
        for (int i = 0; i <= 16; i++) cyc("seq", 1, i % 16);
        chk("seq.step_count", 32'(step_seen), 32'd16);
        chk("seq.wrap_cnt", 32'(wrap_cnt), 32'd1);
        chk("seq.jump_cnt", 32'(jump_cnt), 32'd0);
        cyc("idle", 0, 0);

        // stall: 9 samples of 3 then step to 4
        cyc("clr", 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc("hold", 1, 3);
        chk("stall.rise", 32'(stall_flag), 32'd1);
        cyc("stall.exit", 1, 4);
        chk("stall.exit_flag", 32'(stall_flag), 32'd0);
        chk("stall.exit_step", 32'(step_pulse), 32'd1);

        // jump 5 -> 12
        cyc("j5", 1, 5);
        cyc("j12", 1, 12);
        cyc("jidle", 0, 0);

        // match on 9 with match_en on and off
        match_val = 4'd9;
        match_en  = 1'b1;
        for (int i = 6; i <= 11; i++) cyc("match_on", 1, i);
        match_en = 1'b0;
        for (int i = 6; i <= 11; i++) cyc("match_off", 1, i);

        // wrap counter saturation, then clear with a coincident sample
        cyc("clr2", 0, 0, 1);
        cyc("sat.load", 1, 15);
        for (int i = 0; i < 5; i++) begin
            cyc("sat.w", 1, 0);
            cyc("sat.j", 1, 15);
        end
        chk("sat.wrap_cnt", 32'(wrap_cnt), 32'(CNT_MAX));
        cyc("clr_with_sample", 1, 0, 1);
        chk("clr.wrap_cnt", 32'(wrap_cnt), 32'd0);
        chk("clr.last_kept", 32'(last_val), 32'd15);
        cyc("after_clr", 1, 0);
        chk("after_clr.step", 32'(step_pulse), 32'd0);

        // async reset mid-stall with wrap_cnt = 2
        cyc("pre.load", 1, 15);
        cyc("pre.w1", 1, 0);
        for (int i = 1; i <= 15; i++) cyc("pre.up", 1, i);
        cyc("pre.w2", 1, 0);
        for (int i = 0; i < 8; i++) cyc("pre.hold", 1, 0);
        chk("pre.stall", 32'(stall_flag), 32'd1);
        chk("pre.wcnt", 32'(wrap_cnt), 32'd2);
        @(negedge clk);
        cnt_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post.load", 1, 6);
        cyc("post.step", 1, 7);

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            int r;
            int v;
            if (n % 25 == 0) begin
                match_en  = $urandom_range(0, 1);
                match_val = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 9);
            if (r < 4)      v = m_last;
            else if (r < 7) v = (m_last + 1) % 16;
            else            v = $urandom_range(0, 15);
            cyc("rand", $urandom_range(0, 3) != 0, v, $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream observer for the 4-bit preset/clear/load/increment counter register. Samples the counter's 4-bit output each qualified cycle and classifies every change as step, wrap, hold or jump. Drives registered event pulses, saturating statistics and a stall detector for the surrounding control logic. Purely passive: never drives the counter.

## Interface
Parameters:
- STALL_LEN, default 8 — consecutive hold samples that declare a stall; legal range 2..255.
- CNT_W, default 8 — width of wrap_cnt and jump_cnt.

Ports:
- clk  input  1  — single clock, rising edge.
- rst_n  input  1  — reset, asynchronous, active-low.
- cnt_in  input  4  — counter value under observation.
- cnt_vld  input  1  — cnt_in is sampled on this edge when 1.
- clr_stats  input  1  — synchronous clear of statistics and tracking state.
- match_val  input  4  — compare value.
- match_en  input  1  — enables match detection.
- step_pulse  output  1  — one-cycle pulse: sample = previous + 1, mod 16, including wrap.
- wrap_pulse  output  1  — one-cycle pulse: previous = 15 and sample = 0.
- jump_pulse  output  1  — one-cycle pulse: sample neither previous, previous+1 mod 16.
- match_pulse  output  1  — one-cycle pulse: match_en=1 and sample = match_val.
- stall_flag  output  1  — level; high while in STALL.
- wrap_cnt  output  CNT_W  — saturating count of wraps.
- jump_cnt  output  CNT_W  — saturating count of jumps.
- last_val  output  4  — most recent accepted sample.

## Operation
- States: EMPTY (no previous sample), TRACK, STALL.
- The previous sample, p, is the value in last_val. The new sample, s, is cnt_in on the edge with cnt_vld=1.
- EMPTY + sample: load last_val = s, go to TRACK. Do not classify (no step/wrap/jump/hold). match is still evaluated.
- TRACK/STALL + sample: classify s against p.
  - step: s == p+1 (4-bit wrap arithmetic). wrap is the subset where p=15, s=0.
  - hold: s == p.
  - jump: anything else.
  - last_val <= s.
- Hold-run counter, ceil(log2(STALL_LEN+1)) bits:
  - Increments on hold. Clears on step or jump.
  - TRACK -> STALL when the run reaches STALL_LEN.
  - STALL -> TRACK on the first step or jump. In the same edge stall_flag falls and the event pulse fires.
  - Further holds in STALL keep STALL. The run counter saturates.
- wrap_cnt and jump_cnt: +1 on each wrap or jump. They hold at 2^CNT_W−1 and never roll over.
- clr_stats=1 on an edge:
  - Clears wrap_cnt, jump_cnt, the hold run, stall_flag and all pulses.
  - State goes to EMPTY. last_val is kept.
  - Overrides any simultaneous sample: that sample is discarded and not classified.
- cnt_vld=0: no state change. All pulses go to 0 on the next edge.

## Timing
- All outputs are registered.
- Latency: a sample on edge N drives its pulses, counters and last_val updates visible after edge N, for exactly one cycle.
- Back-to-back samples produce back-to-back pulses with no bubble.
- stall_flag rises after the edge that accepts the STALL_LEN-th consecutive hold.
- Reset (rst_n low, any time, including mid-run), all immediately:
  - state = EMPTY.
  - last_val = 0, wrap_cnt = 0, jump_cnt = 0, hold run = 0.
  - All pulses = 0, stall_flag = 0.
- Operation resumes on the first edge after rst_n rises.
- Counter preset (value 15) and clear (value 0) show up here as ordinary samples. Example: 7 -> 15 classifies as a jump; 15 -> 0 classifies as a wrap.

## Configuration
- COUNT_MONITOR_JUMP_EN defined: jump classification, jump_pulse and jump_cnt behave as specified above.
- COUNT_MONITOR_JUMP_EN undefined:
  - jump_pulse and jump_cnt are tied to 0 and their logic is removed.
  - Non-step, non-hold samples still clear the hold run and still exit STALL.
  - Step, wrap, match and stall behaviour is unchanged.

## Test plan
- Reset, then samples 0,1,2…15,0 on consecutive cycles:
  - step_pulse high for 16 cycles, starting at the second sample.
  - wrap_pulse exactly once, on 15 -> 0.
  - wrap_cnt = 1, jump_cnt = 0.
- Samples 3,3,3… with STALL_LEN=8:
  - stall_flag rises after the 8th hold (9th sample of 3).
  - Next sample 4: stall_flag drops and step_pulse fires in the same cycle.
- Samples 5 then 12 (macro defined): jump_pulse one cycle, jump_cnt = 1. Same with macro undefined: jump_pulse stays 0, jump_cnt = 0.
- match_en=1, match_val=9, counter incrementing 6..11: match_pulse only one cycle after the sample of 9. With match_en=0: no pulse.
- CNT_W=2, 5 wraps: wrap_cnt saturates at 3. Then clr_stats together with a valid sample:
  - wrap_cnt = 0, state EMPTY, sample not classified.
  - The next sample produces no step/jump pulse.
- rst_n low mid-stall with wrap_cnt = 2:
  - All outputs 0 immediately, asynchronously.
  - First sample after release only loads last_val.
